// File: rtl/systolic_seq_ctrl.sv
// Pass sequencer for an output-stationary ARRAY_DIM x ARRAY_DIM systolic tile.
// Optional perf counters are compiled in with `define SEQ_PERF_CNT_EN.
module systolic_seq_ctrl #(
    parameter int ARRAY_DIM  = 4,
    parameter int K_WIDTH    = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [K_WIDTH-1:0]           k_len,
    input  logic                         stall,
    output logic                         busy,
    output logic                         done,
    output logic                         pe_clear_acc,
    output logic                         pe_load_weight,
    output logic [ARRAY_DIM-1:0]         pe_row_en,
    output logic                         wt_rd_en,
    output logic [ADDR_WIDTH-1:0]        wt_rd_addr,
    output logic                         act_rd_en,
    output logic [ADDR_WIDTH-1:0]        act_rd_addr,
    output logic                         out_valid,
    output logic [$clog2(ARRAY_DIM)-1:0] out_row_sel
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                  perf_busy_cycles,
    output logic [31:0]                  perf_stall_cycles
`endif
);

    localparam int CLOG_DR = $clog2(2*ARRAY_DIM+1);
    localparam int CW      = (K_WIDTH > CLOG_DR) ? K_WIDTH : CLOG_DR;
    localparam int RW      = $clog2(ARRAY_DIM);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_LOAD_W  = 3'd2;
    localparam logic [2:0] S_STREAM  = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;
    localparam logic [2:0] S_READOUT = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam logic [CW-1:0] LW_LAST = CW'(ARRAY_DIM);
    localparam logic [CW-1:0] DR_LAST = CW'(2*ARRAY_DIM-1);
    localparam logic [CW-1:0] RO_LAST = CW'(ARRAY_DIM-1);

    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [K_WIDTH-1:0]   k_q;
    logic [ARRAY_DIM-1:0] skew;
    logic [CW-1:0]        k_last;

    assign k_last = CW'(k_q) - CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            k_q   <= '0;
            skew  <= '0;
        end else if (!stall) begin
            // skew[r] holds the stream enable from r+1 unstalled cycles ago
            skew <= {skew[ARRAY_DIM-2:0], act_rd_en};
            cnt  <= cnt + CW'(1);
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        k_q   <= k_len;
                        skew  <= '0;
                        state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    cnt   <= '0;
                    state <= S_LOAD_W;
                end
                S_LOAD_W: if (cnt == LW_LAST) begin
                    cnt   <= '0;
                    state <= (k_q == '0) ? S_DRAIN : S_STREAM;
                end
                S_STREAM: if (cnt == k_last) begin
                    cnt   <= '0;
                    state <= S_DRAIN;
                end
                S_DRAIN: if (cnt == DR_LAST) begin
                    cnt   <= '0;
                    state <= S_READOUT;
                end
                S_READOUT: if (cnt == RO_LAST) begin
                    cnt   <= '0;
                    state <= S_DONE;
                end
                S_DONE: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes drop during stall; addresses follow the held counter.
    assign busy           = (state != S_IDLE);
    assign done           = (state == S_DONE) && !stall;
    assign pe_clear_acc   = (state == S_CLEAR) && !stall;
    assign wt_rd_en       = (state == S_LOAD_W) && (cnt < LW_LAST) && !stall;
    assign pe_load_weight = (state == S_LOAD_W) && (cnt != '0) && !stall;
    assign act_rd_en      = (state == S_STREAM) && !stall;
    assign out_valid      = (state == S_READOUT) && !stall;
    assign pe_row_en      = stall ? '0 : skew;
    assign wt_rd_addr     = (state == S_LOAD_W)  ? ADDR_WIDTH'(cnt) : '0;
    assign act_rd_addr    = (state == S_STREAM)  ? ADDR_WIDTH'(cnt) : '0;
    assign out_row_sel    = (state == S_READOUT) ? RW'(cnt) : '0;

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || (state == S_IDLE && start && !stall)) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (busy && !(&perf_busy_cycles))
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            if (busy && stall && !(&perf_stall_cycles))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: pass-position reference model plus directed literal checks.
module tb_systolic_seq_ctrl;

    localparam int AD = 4;
    localparam int KW = 8;
    localparam int AW = 8;
    localparam int RW = $clog2(AD);

    logic          clk = 1'b0;
    logic          rst, start, stall;
    logic [KW-1:0] k_len;
    logic          busy, done, pe_clear_acc, pe_load_weight, wt_rd_en, act_rd_en, out_valid;
    logic [AD-1:0] pe_row_en;
    logic [AW-1:0] wt_rd_addr, act_rd_addr;
    logic [RW-1:0] out_row_sel;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0]   perf_busy_cycles, perf_stall_cycles;
`endif

    systolic_seq_ctrl #(.ARRAY_DIM(AD), .K_WIDTH(KW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .stall(stall),
        .busy(busy), .done(done), .pe_clear_acc(pe_clear_acc),
        .pe_load_weight(pe_load_weight), .pe_row_en(pe_row_en),
        .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr),
        .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr),
        .out_valid(out_valid), .out_row_sel(out_row_sel)
`ifdef SEQ_PERF_CNT_EN
        , .perf_busy_cycles(perf_busy_cycles), .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: a pass is a sequence of L positions; stalls freeze the position.
    bit    m_busy = 1'b0;
    int    m_p = 0, m_k = 0;
    longint m_pb = 0, m_ps = 0;

    bit          s_busy, s_done, s_act;
    logic [AD-1:0] s_row;
    int          s_act_addr;
    longint      s_pb;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic compare();
        logic [10:0] e_ctl, a_ctl;
        logic [AD-1:0] e_row;
        int p, j, s, rd, t, len;
        e_ctl = '0;
        e_row = '0;
        if (m_busy) begin
            p   = m_p;
            len = 4*AD + 3 + m_k;
            j   = p - 1;
            s   = p - (AD + 2);
            rd  = p - (AD + 2 + m_k + 2*AD);
            for (int r = 0; r < AD; r++) begin
                t = p - 1 - r - (AD + 2);
                e_row[r] = (t >= 0 && t < m_k) && !stall;
            end
            e_ctl = {1'b1,
                     (p == len-1) && !stall,
                     (p == 0) && !stall,
                     (j >= 1 && j <= AD) && !stall,
                     (j >= 0 && j < AD) && !stall,
                     (s >= 0 && s < m_k) && !stall,
                     (rd >= 0 && rd < AD) && !stall,
                     e_row};
            if (j >= 0 && j < AD)   chk("wt_rd_addr", wt_rd_addr, j);
            if (s >= 0 && s < m_k)  chk("act_rd_addr", act_rd_addr, s);
            if (rd >= 0 && rd < AD) chk("out_row_sel", out_row_sel, rd);
        end
        a_ctl = {busy, done, pe_clear_acc, pe_load_weight, wt_rd_en, act_rd_en, out_valid, pe_row_en};
        chk("ctl_vector", a_ctl, e_ctl);
`ifdef SEQ_PERF_CNT_EN
        chk("perf_busy", perf_busy_cycles, m_pb);
        chk("perf_stall", perf_stall_cycles, m_ps);
        s_pb = perf_busy_cycles;
`else
        s_pb = 0;
`endif
        s_busy = busy; s_done = done; s_act = act_rd_en; s_row = pe_row_en;
        s_act_addr = int'(act_rd_addr);
    endtask

    task automatic model_edge();
        if (rst) begin
            m_busy = 1'b0; m_pb = 0; m_ps = 0;
        end else if (!m_busy) begin
            if (start && !stall) begin
                m_busy = 1'b1; m_p = 0; m_k = int'(k_len); m_pb = 0; m_ps = 0;
            end
        end else begin
            if (m_pb < 64'hFFFF_FFFF) m_pb++;
            if (stall && m_ps < 64'hFFFF_FFFF) m_ps++;
            if (!stall) begin
                if (m_p == 4*AD + 3 + m_k - 1) m_busy = 1'b0;
                else m_p++;
            end
        end
    endtask

    // One clock: check outputs mid-cycle, then advance model with the edge.
    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic do_pass(input int k, input int st_at, input int st_len,
                           output int nbusy, output int nact, output int nrow0, output int nrow3,
                           output int fact, output int frow0, output int frow3,
                           output bit gdone, output int st_addr);
        nbusy = 0; nact = 0; nrow0 = 0; nrow3 = 0;
        fact = -1; frow0 = -1; frow3 = -1; gdone = 1'b0; st_addr = -1;
        start = 1'b1; k_len = KW'(k);
        step();
        start = 1'b0;
        for (int c = 0; c < 400 && !gdone; c++) begin
            stall = (c >= st_at) && (c < st_at + st_len);
            step();
            if (s_busy) nbusy++;
            if (s_act) begin nact++; if (fact < 0) fact = c; end
            if (s_row[0]) begin nrow0++; if (frow0 < 0) frow0 = c; end
            if (s_row[AD-1]) begin nrow3++; if (frow3 < 0) frow3 = c; end
            if (c == st_at) st_addr = s_act_addr;
            if (s_done) gdone = 1'b1;
        end
        stall = 1'b0;
        if (!gdone) chk("pass_timeout", 0, 1);
    endtask

    int nb, na, n0, n3, fa, f0, f3, sa, pass_len, passes;
    bit gd;

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; k_len = '0;
        @(posedge clk); #1;
        step(); step();
        chk("reset_outputs", {busy, done, pe_clear_acc, pe_load_weight, pe_row_en, wt_rd_en,
                              act_rd_en, out_valid, wt_rd_addr, act_rd_addr, out_row_sel}, 0);
        rst = 1'b0;
        step();

        // Nominal pass
        do_pass(8, 1000, 0, nb, na, n0, n3, fa, f0, f3, gd, sa);
        chk("k8_busy_cycles", nb, 27);
        chk("k8_act_cycles", na, 8);
        chk("k8_row0_cycles", n0, 8);
        chk("k8_row3_cycles", n3, 8);
        chk("k8_row0_lag", f0 - fa, 1);
        chk("k8_row3_lag", f3 - fa, 4);
        chk("k8_done", gd, 1);
        step();

        // Empty stream
        do_pass(0, 1000, 0, nb, na, n0, n3, fa, f0, f3, gd, sa);
        chk("k0_busy_cycles", nb, 19);
        chk("k0_act_cycles", na, 0);
        chk("k0_row_cycles", n0 + n3, 0);
        chk("k0_done", gd, 1);
        step();

        // 3-cycle stall at STREAM cycle 2 (busy cycle 8)
        do_pass(8, 8, 3, nb, na, n0, n3, fa, f0, f3, gd, sa);
        chk("stall_busy_cycles", nb, 30);
        chk("stall_act_addr", sa, 2);
        chk("stall_act_cycles", na, 8);
        chk("stall_row0_cycles", n0, 8);
        chk("stall_row3_cycles", n3, 8);
        step();

        // Reset during DRAIN
        start = 1'b1; k_len = 8'd8;
        step();
        start = 1'b0;
        for (int c = 0; c < 16; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("rst_abort_busy", s_busy, 0);
        chk("rst_abort_done", s_done, 0);
        do_pass(8, 1000, 0, nb, na, n0, n3, fa, f0, f3, gd, sa);
        chk("post_rst_busy_cycles", nb, 27);

        // Start held high: back-to-back passes of k_len=1
        start = 1'b1; k_len = 8'd1;
        pass_len = 0; passes = 0;
        for (int c = 0; c < 200 && passes < 3; c++) begin
            step();
            if (s_busy) pass_len++;
            if (s_done) begin
                chk("b2b_busy_cycles", pass_len, 20);
                pass_len = 0;
                passes++;
`ifdef SEQ_PERF_CNT_EN
                step();
                chk("b2b_perf_busy", s_pb, 20);
`endif
            end
        end
        chk("b2b_passes", passes, 3);
        start = 1'b0;
        for (int c = 0; c < 40; c++) step();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rst   = ($urandom_range(0, 499) == 0);
            start = ($urandom_range(0, 3) == 0);
            stall = ($urandom_range(0, 5) == 0);
            k_len = ($urandom_range(0, 19) == 0) ? KW'($urandom_range(0, 255))
                                                 : KW'($urandom_range(0, 12));
            step();
        end
        rst = 1'b0; start = 1'b0; stall = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
